// File: rtl/shift_pkg.sv
// Shared types for shift_serializer: FSM state encoding and default word width.
// The PARITY state exists only when SHIFT_SERIALIZER_PARITY_EN is defined.
package shift_pkg;

    localparam int DEFAULT_WIDTH = 6;

`ifdef SHIFT_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;
`else
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;
`endif

endpackage

// File: rtl/shift_serializer.sv
// Parallel-to-serial shifter with valid/ready load handshake, falling-edge clocked.
// Define SHIFT_SERIALIZER_PARITY_EN to append one even-parity bit after each word.
module shift_serializer
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             LoadValid,
    input  logic [WIDTH-1:0] LoadData,
    input  logic             ShiftLeft,
    output logic             LoadReady,
    output logic             SerialOut,
    output logic             SerialValid,
    output logic             Busy,
    output logic             Done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic               dir_q, dir_d;
`ifdef SHIFT_SERIALIZER_PARITY_EN
    logic               parity_q, parity_d;
`endif

    // NOTE: every output and next-state value gets a default first, so no path
    // through the case leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        dir_d       = dir_q;
`ifdef SHIFT_SERIALIZER_PARITY_EN
        parity_d    = parity_q;
`endif
        LoadReady   = 1'b0;
        SerialOut   = 1'b0;
        SerialValid = 1'b0;
        Busy        = 1'b0;
        Done        = 1'b0;

        case (state_q)
            IDLE: begin
                LoadReady = 1'b1;
            end
            SHIFT: begin
                SerialValid = 1'b1;
                Busy        = 1'b1;
                SerialOut   = dir_q ? shreg_q[WIDTH-1] : shreg_q[0];
                cnt_d       = cnt_q - CNT_W'(1);
                shreg_d     = dir_q ? {shreg_q[WIDTH-2:0], 1'b0}
                                    : {1'b0, shreg_q[WIDTH-1:1]};
                if (cnt_q == CNT_W'(1)) begin
`ifdef SHIFT_SERIALIZER_PARITY_EN
                    state_d   = PARITY;
`else
                    Done      = 1'b1;
                    LoadReady = 1'b1;
                    state_d   = IDLE;
`endif
                end
            end
`ifdef SHIFT_SERIALIZER_PARITY_EN
            PARITY: begin
                SerialValid = 1'b1;
                Busy        = 1'b1;
                SerialOut   = parity_q;
                Done        = 1'b1;
                LoadReady   = 1'b1;
                state_d     = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        // A word offered in IDLE or in the final output cycle starts immediately,
        // which gives back-to-back words with no idle gap.
        if (LoadValid && LoadReady) begin
            state_d  = SHIFT;
            cnt_d    = CNT_W'(WIDTH);
            shreg_d  = LoadData;
            dir_d    = ShiftLeft;
`ifdef SHIFT_SERIALIZER_PARITY_EN
            parity_d = ^LoadData;
`endif
        end
    end

    // NOTE: state uses non-blocking assignments so all flops sample their
    // next-state values from the same falling edge.
    always_ff @(negedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shreg_q  <= '0;
            dir_q    <= 1'b0;
`ifdef SHIFT_SERIALIZER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            dir_q    <= dir_d;
`ifdef SHIFT_SERIALIZER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_shift_serializer.sv
// Self-checking bench for shift_serializer: directed cases plus random traffic
// compared against a queue-of-expected-bits reference model.
module tb_shift_serializer;

    localparam int W = 6;
`ifdef SHIFT_SERIALIZER_PARITY_EN
    localparam int WPB = W + 1;
`else
    localparam int WPB = W;
`endif

    logic         Clock = 1'b0;
    logic         ResetN;
    logic         LoadValid;
    logic [W-1:0] LoadData;
    logic         ShiftLeft;
    logic         LoadReady;
    logic         SerialOut;
    logic         SerialValid;
    logic         Busy;
    logic         Done;

    int total = 0;
    int bad   = 0;

    // Reference model: bits still owed to the serial line, oldest first.
    bit exp_q[$];

    logic [31:0] rec_bits;
    int          rec_n;
    int          done_cnt;
    int          done_pos;

    shift_serializer #(.WIDTH(W)) dut (
        .Clock       (Clock),
        .ResetN      (ResetN),
        .LoadValid   (LoadValid),
        .LoadData    (LoadData),
        .ShiftLeft   (ShiftLeft),
        .LoadReady   (LoadReady),
        .SerialOut   (SerialOut),
        .SerialValid (SerialValid),
        .Busy        (Busy),
        .Done        (Done)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [W-1:0] d, input logic sl);
        for (int i = 0; i < W; i++) exp_q.push_back(sl ? d[W-1-i] : d[i]);
`ifdef SHIFT_SERIALIZER_PARITY_EN
        exp_q.push_back(^d);
`endif
    endtask

    task automatic rec_clear();
        rec_bits = '0;
        rec_n    = 0;
        done_cnt = 0;
        done_pos = 0;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then let
    // the falling edge consume one owed bit and possibly accept a new word.
    task automatic cycle(input logic lv, input logic [W-1:0] d, input logic sl);
        logic exp_valid, exp_out, exp_ready, exp_done;
        bit   acc;
        LoadValid = lv;
        LoadData  = d;
        ShiftLeft = sl;
        #1;
        exp_valid = exp_q.size() > 0;
        exp_out   = exp_valid ? exp_q[0] : 1'b0;
        exp_ready = exp_q.size() <= 1;
        exp_done  = exp_q.size() == 1;
        check("serial_out",   32'(SerialOut),   32'(exp_out));
        check("serial_valid", 32'(SerialValid), 32'(exp_valid));
        check("busy",         32'(Busy),        32'(exp_valid));
        check("load_ready",   32'(LoadReady),   32'(exp_ready));
        check("done",         32'(Done),        32'(exp_done));
        if (SerialValid === 1'b1) begin
            rec_bits = {rec_bits[30:0], SerialOut};
            rec_n++;
        end
        if (Done === 1'b1) begin
            done_cnt++;
            done_pos = rec_n;
        end
        acc = lv && exp_ready;
        @(negedge Clock);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (acc) push_word(d, sl);
        @(posedge Clock);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_out"},   32'(SerialOut),   32'd0);
        check({tag, "_valid"}, 32'(SerialValid), 32'd0);
        check({tag, "_busy"},  32'(Busy),        32'd0);
        check({tag, "_done"},  32'(Done),        32'd0);
        check({tag, "_ready"}, 32'(LoadReady),   32'd1);
    endtask

    initial begin
        ResetN    = 1'b0;
        LoadValid = 1'b0;
        LoadData  = '0;
        ShiftLeft = 1'b0;
        rec_clear();
        #2;
        check_idle_outputs("reset");
        @(posedge Clock);
        #1;
        ResetN = 1'b1;

        // MSB first: 101100 -> 1,0,1,1,0,0
        rec_clear();
        cycle(1'b1, 6'b101100, 1'b1);
        for (int i = 0; i < WPB; i++) cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        check("msb_count", 32'(rec_n), 32'(WPB));
        check("msb_bits",  rec_bits >> (WPB - W), 32'b101100);
        check("msb_done_n", 32'(done_cnt), 32'd1);
        check("msb_done_at", 32'(done_pos), 32'(WPB));

        // LSB first: 101100 -> 0,0,1,1,0,1 while ShiftLeft and LoadData wiggle
        rec_clear();
        cycle(1'b1, 6'b101100, 1'b0);
        for (int i = 0; i < WPB - 1; i++) cycle(1'b0, 6'(i * 7), 1'(i));
        cycle(1'b0, '0, 1'b0);
        check("lsb_count", 32'(rec_n), 32'(WPB));
        check("lsb_bits",  rec_bits >> (WPB - W), 32'b001101);
        check("lsb_done_n", 32'(done_cnt), 32'd1);

        // Back-to-back: second word offered during the final output cycle
        rec_clear();
        cycle(1'b1, 6'b111000, 1'b1);
        for (int i = 0; i < WPB - 1; i++) cycle(1'b0, '0, 1'b0);
        cycle(1'b1, 6'b000111, 1'b1);
        for (int i = 0; i < WPB - 1; i++) cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        check("b2b_count", 32'(rec_n), 32'(2 * WPB));
`ifdef SHIFT_SERIALIZER_PARITY_EN
        check("b2b_bits", rec_bits, 32'b11100010001111);
`else
        check("b2b_bits", rec_bits, 32'b111000000111);
`endif
        check("b2b_done_n", 32'(done_cnt), 32'd2);

        // Reset pulsed during the third bit clears outputs without a clock edge
        cycle(1'b1, 6'b110011, 1'b1);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        check("pre_reset_valid", 32'(SerialValid), 32'd1);
        #1;
        ResetN = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        exp_q.delete();
        @(negedge Clock);
        #1;
        check_idle_outputs("held_reset");
        @(posedge Clock);
        #1;
        ResetN = 1'b1;
        rec_clear();
        cycle(1'b1, 6'b010101, 1'b1);
        for (int i = 0; i < WPB; i++) cycle(1'b0, '0, 1'b0);
        check("post_reset_count", 32'(rec_n), 32'(WPB));
        check("post_reset_bits",  rec_bits >> (WPB - W), 32'b010101);

`ifdef SHIFT_SERIALIZER_PARITY_EN
        rec_clear();
        cycle(1'b1, 6'b101100, 1'b1);
        for (int i = 0; i < WPB; i++) cycle(1'b0, '0, 1'b0);
        check("par_bit_a",  32'(rec_bits[0]), 32'd1);
        check("par_done_a", 32'(done_pos), 32'd7);
        rec_clear();
        cycle(1'b1, 6'b110000, 1'b1);
        for (int i = 0; i < WPB; i++) cycle(1'b0, '0, 1'b0);
        check("par_bit_b",  32'(rec_bits[0]), 32'd0);
`endif

        // Random traffic against the model
        for (int i = 0; i < 200; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 6'($urandom), 1'($urandom));
        end
        for (int i = 0; i < WPB + 1; i++) cycle(1'b0, '0, 1'b0);
        check_idle_outputs("final_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
